// File: rtl/axi_lite_mgr_queued.sv
// rtl/axi_lite_mgr_queued.sv - queued AXI4-Lite manager with in-order registered responses
// Commands are buffered, issued one direction at a time, and results returned through a one-entry response register.
module axi_lite_mgr_queued #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int MAX_OUT   = 4
) (
  input  logic                          aCLK,
  input  logic                          ARESETn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_W-1:0]             cmd_addr,
  input  logic [DATA_W-1:0]             cmd_data,
  input  logic [DATA_W/8-1:0]           cmd_strb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [DATA_W-1:0]             rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic                          AWVALID,
  input  logic                          AWREADY,
  output logic [ADDR_W-1:0]             AWADDR,
  output logic                          WVALID,
  input  logic                          WREADY,
  output logic [DATA_W-1:0]             WDATA,
  output logic [DATA_W/8-1:0]           WSTRB,
  input  logic                          BVALID,
  output logic                          BREADY,
  input  logic [1:0]                    BRESP,
  output logic                          ARVALID,
  input  logic                          ARREADY,
  output logic [ADDR_W-1:0]             ARADDR,
  input  logic                          RVALID,
  output logic                          RREADY,
  input  logic [DATA_W-1:0]             RDATA,
  input  logic [1:0]                    RRESP,
  output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
  output logic                          err_seen
);
  localparam int PTR_W  = $clog2(CMD_DEPTH);
  localparam int CNT_W  = $clog2(CMD_DEPTH+1);
  localparam int OUT_W  = $clog2(MAX_OUT+1);
  localparam int STRB_W = DATA_W/8;
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(CMD_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DRAIN} state_t;

  logic              mem_write [CMD_DEPTH];
  logic [ADDR_W-1:0] mem_addr  [CMD_DEPTH];
  logic [DATA_W-1:0] mem_data  [CMD_DEPTH];
  logic [STRB_W-1:0] mem_strb  [CMD_DEPTH];

  state_t            state_q;
  logic              live_q, dir_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OUT_W-1:0]  out_q;
  logic              awvalid_q, wvalid_q, arvalid_q;
  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              rsp_valid_q, rsp_write_q, err_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        rsp_resp_q;

  logic push, pop, head_valid, aw_fin, w_fin, rsp_take, b_hs, r_hs, done;

  assign head_valid = (cnt_q != '0);
  assign cmd_ready  = live_q && (cnt_q != DEPTH_C);
  assign push       = cmd_valid && cmd_ready;
  assign aw_fin     = !awvalid_q || AWREADY;
  assign w_fin      = !wvalid_q || WREADY;
  assign pop        = ((state_q == S_WR) && aw_fin && w_fin) ||
                      ((state_q == S_RD) && arvalid_q && ARREADY);
  // A B/R arriving with nothing in flight is handshaken but dropped.
  assign rsp_take   = live_q && (!rsp_valid_q || rsp_ready);
  assign b_hs       = BVALID && rsp_take && (out_q != '0);
  assign r_hs       = RVALID && rsp_take && (out_q != '0);
  assign done       = b_hs || r_hs;

  assign BREADY = rsp_take;
  assign RREADY = rsp_take;
  assign AWVALID = awvalid_q;
  assign AWADDR  = awaddr_q;
  assign WVALID  = wvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign ARVALID = arvalid_q;
  assign ARADDR  = araddr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_resp    = rsp_resp_q;
  assign outstanding = out_q;
  assign err_seen    = err_q;

  always_ff @(posedge aCLK) begin
    if (push) begin
      mem_write[wr_ptr_q] <= cmd_write;
      mem_addr[wr_ptr_q]  <= cmd_addr;
      mem_data[wr_ptr_q]  <= cmd_data;
      mem_strb[wr_ptr_q]  <= cmd_strb;
    end
  end

  always_ff @(posedge aCLK) begin
    if (!ARESETn) begin
      state_q     <= S_IDLE;
      live_q      <= 1'b0;
      dir_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      case ({pop, done})
        2'b10:   out_q <= out_q + 1'b1;
        2'b01:   out_q <= out_q - 1'b1;
        default: out_q <= out_q;
      endcase

      if (done) begin
        rsp_valid_q <= 1'b1;
        rsp_write_q <= b_hs;
        rsp_data_q  <= b_hs ? '0 : RDATA;
        rsp_resp_q  <= b_hs ? BRESP : RRESP;
        if ((b_hs ? BRESP : RRESP) != 2'b00) err_q <= 1'b1;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (head_valid) begin
            if (out_q == '0 || mem_write[rd_ptr_q] == dir_q) begin
              if (out_q < MAX_OUT_C) begin
                dir_q <= mem_write[rd_ptr_q];
                if (mem_write[rd_ptr_q]) begin
                  awaddr_q  <= mem_addr[rd_ptr_q];
                  wdata_q   <= mem_data[rd_ptr_q];
                  wstrb_q   <= mem_strb[rd_ptr_q];
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  state_q   <= S_WR;
                end else begin
                  araddr_q  <= mem_addr[rd_ptr_q];
                  arvalid_q <= 1'b1;
                  state_q   <= S_RD;
                end
              end
            end else begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_WR: begin
          if (awvalid_q && AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && WREADY)   wvalid_q  <= 1'b0;
          if (aw_fin && w_fin)      state_q   <= S_IDLE;
        end
        S_RD: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          // Direction only changes once the bus is empty of the old direction.
          if (out_q == '0) begin
            dir_q   <= ~dir_q;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule
